// File: rtl/multi_channel_delay_line.sv
// multi_channel_delay_line: N independent shift-register delay lanes with runtime-selectable tap
//
// Each channel is a MAX_DELAY-stage pipeline of {valid, data}. The output tap
// is stage[cur_delay-1], so a sample captured on edge t is visible right after
// edge t+cur_delay-1. Loading a new delay, or flushing, drops every valid tag of
// the affected channel(s), including the sample entering on that edge, so a
// retune can never replay or skip a sample marked valid.
//
// Optional build macro: DELAY_LINE_PARITY_EN
//   When defined, every stage carries an even-parity bit of the captured data,
//   and the output tap checks it. A sticky parity_err bit per channel is set by
//   any valid output with a mismatch and is cleared only by reset.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   data_in     NUM_CHANNELS*DATA_WIDTH input samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   valid_in    per-channel input qualifier
//   delay_sel   NUM_CHANNELS*DSEL_W requested delay (clamped to 1..MAX_DELAY)
//   load_delay  per-channel strobe that latches delay_sel
//   flush       synchronous clear of all valid tags
//   data_out    delayed data per channel
//   valid_out   delayed valid per channel
//   busy        per-channel OR of all stage valid tags
//   cur_delay   active delay per channel
//   parity_err  (parity build only) sticky per-channel parity error
module multi_channel_delay_line #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int MAX_DELAY    = 8,
    localparam int DSEL_W      = $clog2(MAX_DELAY + 1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CHANNELS-1:0]            valid_in,
    input  logic [NUM_CHANNELS*DSEL_W-1:0]     delay_sel,
    input  logic [NUM_CHANNELS-1:0]            load_delay,
    input  logic                               flush,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CHANNELS-1:0]            valid_out,
    output logic [NUM_CHANNELS-1:0]            busy,
`ifdef DELAY_LINE_PARITY_EN
    output logic [NUM_CHANNELS-1:0]            parity_err,
`endif
    output logic [NUM_CHANNELS*DSEL_W-1:0]     cur_delay
);

    logic [DATA_WIDTH-1:0] data_q [NUM_CHANNELS][MAX_DELAY];
    logic [DATA_WIDTH-1:0] data_d [NUM_CHANNELS][MAX_DELAY];
    logic [MAX_DELAY-1:0]  vld_q  [NUM_CHANNELS];
    logic [MAX_DELAY-1:0]  vld_d  [NUM_CHANNELS];
    logic [DSEL_W-1:0]     dly_q  [NUM_CHANNELS];
    logic [DSEL_W-1:0]     dly_d  [NUM_CHANNELS];

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        dly_d  = dly_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            data_d[c][0] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            for (int k = 1; k < MAX_DELAY; k++)
                data_d[c][k] = data_q[c][k-1];
            // a retune or flush invalidates the whole lane, incoming sample included
            vld_d[c] = (flush || load_delay[c]) ? '0
                     : {vld_q[c][MAX_DELAY-2:0], valid_in[c]};
            if (load_delay[c])
                dly_d[c] = (delay_sel[c*DSEL_W +: DSEL_W] == '0) ? DSEL_W'(1)
                         : (delay_sel[c*DSEL_W +: DSEL_W] > DSEL_W'(MAX_DELAY)) ? DSEL_W'(MAX_DELAY)
                         : delay_sel[c*DSEL_W +: DSEL_W];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '{default: '0};
            vld_q  <= '{default: '0};
            dly_q  <= '{default: DSEL_W'(MAX_DELAY)};
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            dly_q  <= dly_d;
        end
    end

    // tap mux: registered stages only, so there is no input-to-output path
    always_comb begin
        data_out  = '0;
        valid_out = '0;
        busy      = '0;
        cur_delay = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            busy[c] = |vld_q[c];
            cur_delay[c*DSEL_W +: DSEL_W] = dly_q[c];
            for (int k = 0; k < MAX_DELAY; k++) begin
                if (dly_q[c] == DSEL_W'(k + 1)) begin
                    data_out[c*DATA_WIDTH +: DATA_WIDTH] = data_q[c][k];
                    valid_out[c] = vld_q[c][k];
                end
            end
        end
    end

`ifdef DELAY_LINE_PARITY_EN
    logic [MAX_DELAY-1:0]    par_q [NUM_CHANNELS];
    logic [MAX_DELAY-1:0]    par_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] par_tap;
    logic [NUM_CHANNELS-1:0] perr_q;
    logic [NUM_CHANNELS-1:0] perr_d;

    always_comb begin
        par_tap = '0;
        perr_d  = perr_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            par_d[c] = {par_q[c][MAX_DELAY-2:0], ^data_in[c*DATA_WIDTH +: DATA_WIDTH]};
            for (int k = 0; k < MAX_DELAY; k++)
                if (dly_q[c] == DSEL_W'(k + 1))
                    par_tap[c] = par_q[c][k];
            if (valid_out[c] && (par_tap[c] != ^data_out[c*DATA_WIDTH +: DATA_WIDTH]))
                perr_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            par_q  <= '{default: '0};
            perr_q <= '0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_multi_channel_delay_line.sv
// tb_multi_channel_delay_line: directed self-checking bench for multi_channel_delay_line
module tb_multi_channel_delay_line;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  valid_in = '0;
    logic [7:0]  delay_sel = '0;
    logic [1:0]  load_delay = '0;
    logic        flush = 1'b0;
    logic [31:0] data_out;
    logic [1:0]  valid_out;
    logic [1:0]  busy;
    logic [7:0]  cur_delay;
`ifdef DELAY_LINE_PARITY_EN
    logic [1:0]  parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] s0 [100];
    logic [15:0] s1 [100];

    multi_channel_delay_line dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .delay_sel  (delay_sel),
        .load_delay (load_delay),
        .flush      (flush),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .busy       (busy),
`ifdef DELAY_LINE_PARITY_EN
        .parity_err (parity_err),
`endif
        .cur_delay  (cur_delay)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 1: reset
        repeat (2) tick();
        check("rst_data", 64'(data_out), 64'h0);
        check("rst_valid", 64'(valid_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_delay", 64'(cur_delay), 64'h88);
        reset = 1'b1;
        tick();
        check("rel_delay", 64'(cur_delay), 64'h88);

        // 2: ch0 delay 4, ch1 delay 1, 100 random samples each
        delay_sel = {4'd1, 4'd4};
        load_delay = 2'b11;
        tick();
        load_delay = 2'b00;
        check("ld_delay", 64'(cur_delay), 64'h14);
        for (int i = 0; i < 100; i++) begin
            s0[i] = 16'($urandom);
            s1[i] = 16'($urandom);
            data_in = {s1[i], s0[i]};
            valid_in = 2'b11;
            tick();
            check("ch1_d1", {valid_out[1], data_out[31:16]}, {1'b1, s1[i]});
            if (i >= 3) check("ch0_d4", {valid_out[0], data_out[15:0]}, {1'b1, s0[i-3]});
            else check("ch0_d4_fill", 64'(valid_out[0]), 64'h0);
        end
        valid_in = 2'b00;
        data_in = '0;
        tick();
        check("ch1_drain", 64'(valid_out[1]), 64'h0);

        // 3: ch0 at delay 6, retune to 2 mid-stream
        delay_sel = {4'd0, 4'd6};
        load_delay = 2'b01;
        tick();
        load_delay = 2'b00;
        check("ch1_untouched", 64'(cur_delay[7:4]), 64'h1);
        for (int i = 0; i < 8; i++) begin
            data_in = {16'h0, 16'(16'hA000 + i)};
            valid_in = 2'b01;
            tick();
        end
        check("d6_stream", {valid_out[0], data_out[15:0]}, {1'b1, 16'hA002});
        data_in = {16'h0, 16'hDEAD};
        delay_sel = {4'd0, 4'd2};
        load_delay = 2'b01;
        tick();
        load_delay = 2'b00;
        check("retune_valid", 64'(valid_out[0]), 64'h0);
        check("retune_busy", 64'(busy[0]), 64'h0);
        check("retune_delay", 64'(cur_delay[3:0]), 64'h2);
        data_in = {16'h0, 16'hB000};
        tick();
        check("retune_nostale", 64'(valid_out[0]), 64'h0);
        data_in = {16'h0, 16'hB001};
        tick();
        check("retune_b0", {valid_out[0], data_out[15:0]}, {1'b1, 16'hB000});
        valid_in = 2'b00;
        tick();
        check("retune_b1", {valid_out[0], data_out[15:0]}, {1'b1, 16'hB001});
        tick();
        check("retune_end", 64'(valid_out[0]), 64'h0);

        // 4: clamp 0 -> 1 and 15 -> 8
        delay_sel = {4'd0, 4'd0};
        load_delay = 2'b01;
        tick();
        load_delay = 2'b00;
        check("clamp_lo", 64'(cur_delay[3:0]), 64'h1);
        data_in = {16'h0, 16'h1234};
        valid_in = 2'b01;
        tick();
        valid_in = 2'b00;
        check("lat1", {valid_out[0], data_out[15:0]}, {1'b1, 16'h1234});
        tick();
        check("lat1_end", 64'(valid_out[0]), 64'h0);
        delay_sel = {4'd0, 4'd15};
        load_delay = 2'b01;
        tick();
        load_delay = 2'b00;
        check("clamp_hi", 64'(cur_delay[3:0]), 64'h8);
        data_in = {16'h0, 16'h5678};
        valid_in = 2'b01;
        tick();
        valid_in = 2'b00;
        data_in = '0;
        repeat (6) tick();
        check("lat8_early", 64'(valid_out[0]), 64'h0);
        tick();
        check("lat8", {valid_out[0], data_out[15:0]}, {1'b1, 16'h5678});
        tick();
        check("lat8_end", 64'(valid_out[0]), 64'h0);

        // 5: flush with 3 samples in flight, load on ch1 in the same edge
        delay_sel = {4'd0, 4'd4};
        load_delay = 2'b01;
        tick();
        load_delay = 2'b00;
        for (int i = 0; i < 3; i++) begin
            data_in = {16'h0, 16'(16'hC000 + i)};
            valid_in = 2'b01;
            tick();
        end
        check("pre_flush_busy", 64'(busy[0]), 64'h1);
        data_in = {16'h0, 16'hF00F};
        flush = 1'b1;
        delay_sel = {4'd3, 4'd4};
        load_delay = 2'b10;
        tick();
        flush = 1'b0;
        load_delay = 2'b00;
        valid_in = 2'b00;
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_valid", 64'(valid_out), 64'h0);
        check("flush_load", 64'(cur_delay), 64'h34);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_quiet", 64'(valid_out[0]), 64'h0);
        end
        data_in = {16'h0, 16'h6006};
        valid_in = 2'b01;
        tick();
        valid_in = 2'b00;
        repeat (3) tick();
        check("post_flush", {valid_out[0], data_out[15:0]}, {1'b1, 16'h6006});

`ifdef DELAY_LINE_PARITY_EN
        check("par_clean", 64'(parity_err), 64'h0);
        data_in = {16'h0, 16'h0003};
        valid_in = 2'b01;
        tick();
        valid_in = 2'b00;
        repeat (2) tick();
        force dut.par_q[0][2] = 1'b1;
        tick();
        release dut.par_q[0][2];
        tick();
        check("par_err", 64'(parity_err), 64'h1);
        repeat (3) tick();
        check("par_sticky", 64'(parity_err), 64'h1);
`endif

        // 6: asynchronous reset between edges while busy
        data_in = {16'h0, 16'hBEEF};
        valid_in = 2'b01;
        tick();
        valid_in = 2'b00;
        repeat (3) tick();
        check("pre_rst_out", {valid_out[0], data_out[15:0]}, {1'b1, 16'hBEEF});
        check("pre_rst_busy", 64'(busy[0]), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_data", 64'(data_out), 64'h0);
        check("arst_valid", 64'(valid_out), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_delay", 64'(cur_delay), 64'h88);
`ifdef DELAY_LINE_PARITY_EN
        check("arst_par", 64'(parity_err), 64'h0);
`endif
        tick();
        reset = 1'b1;
        tick();
        check("rerel_busy", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_delay_line.md
Name: multi_channel_delay_line

Overview:
- Parametrised successor to the fixed-depth delay chain.
- N independent channels, each a DATA_WIDTH-bit shift pipeline of MAX_DELAY stages with per-stage valid tags.
- Per-channel delay is runtime-programmable (1..MAX_DELAY cycles) via a tap mux; synchronous flush provided.
- Sits between datapath stages that need run-time-tunable latency alignment (e.g. matching operand arrival across lanes).

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- NUM_CHANNELS, 2, independent delay lanes.
- MAX_DELAY, 8, number of register stages per channel; legal ≥ 2.
- DSEL_W, $clog2(MAX_DELAY+1), width of one channel's delay field (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (block held in reset while 0).
- data_in  in  NUM_CHANNELS*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  NUM_CHANNELS  per-channel input qualifier.
- delay_sel  in  NUM_CHANNELS*DSEL_W  requested delay per channel.
- load_delay  in  NUM_CHANNELS  per-channel strobe: latch delay_sel into the channel's delay register.
- flush  in  1  synchronous clear of all valid tags, all channels.
- data_out  out  NUM_CHANNELS*DATA_WIDTH  delayed data per channel.
- valid_out  out  NUM_CHANNELS  delayed valid per channel.
- busy  out  NUM_CHANNELS  1 when any stage of the channel holds a valid sample.
- cur_delay  out  NUM_CHANNELS*DSEL_W  currently active delay per channel.

Behaviour:
- Reset (reset==0, asynchronous):
  - All stage data = 0, all valid tags = 0, every cur_delay = MAX_DELAY.
  - Outputs: data_out = 0, valid_out = 0, busy = 0.
- Pipeline:
  - Every rising edge, stage0 <= {valid_in[c], data_in[c]}; stage k <= stage k-1.
  - All stages always shift (no stall); data shifts even when valid=0.
- Output tap: {valid_out[c], data_out[c]} = stage[cur_delay[c]-1].
  - Outputs come straight from registers through the mux; no combinational input-to-output path.
- Latency: a sample present before edge t appears on the outputs immediately after edge t+d-1, where d = cur_delay. With d=4 it is visible after 4 rising edges, matching the legacy 4-cycle chain.
- Delay load: on an edge with load_delay[c]=1, cur_delay[c] <= clamp(delay_sel[c]).
  - clamp: 0 -> 1; values > MAX_DELAY -> MAX_DELAY.
  - The same edge clears all valid tags of channel c. The sample entering at that edge is also dropped, so no duplicated or skipped samples are ever marked valid.
  - Data bits are not cleared.
  - Other channels are unaffected.
- Flush: on an edge with flush=1, all valid tags in all channels are cleared, including the incoming sample. Data still shifts. Flush has priority over valid_in; a load_delay on the same edge still updates cur_delay.
- busy[c] = OR of all MAX_DELAY valid tags of channel c, including stages beyond the current tap.
- Simultaneous load_delay on several channels is legal; each channel is handled independently.
- Reset asserted mid-operation: immediate return to the reset state; in-flight samples are lost.
- delay_sel is don't-care when load_delay[c]=0.

Optional Feature:
- Macro: DELAY_LINE_PARITY_EN.
- Defined:
  - Each stage carries an even-parity bit computed over data_in at stage 0.
  - At the output tap, parity is recomputed over data_out.
  - Adds output parity_err (NUM_CHANNELS, sticky). It is set when valid_out[c]=1 and the parity mismatches, and cleared only by reset.
  - Verification injects errors with a force on a stage register.
- Undefined: no parity storage, no parity_err port; area equals base.

Test Plan:
1. Reset=0 for 2 cycles, then release -> data_out=0, valid_out=0, busy=0, cur_delay=8 on both channels.
2. Ch0 load delay 4, ch1 load delay 1; drive 100 random valid samples per channel -> ch0 output equals input exactly 4 edges later, ch1 exactly 1 edge later, valid_out aligned.
3. Streaming ch0 at delay 6, then load_delay with delay_sel=2 mid-stream -> next edge: valid_out[0]=0 and busy[0]=0. New samples then emerge after 2 edges; no stale sample is marked valid.
4. delay_sel=0 then delay_sel=15 (MAX_DELAY=8) -> cur_delay reads 1 then 8; latencies are 1 and 8 edges.
5. flush=1 together with valid_in=1 while 3 samples are in flight -> all valid_out stay 0 until new post-flush samples arrive; busy drops to 0 the edge after flush.
6. Reset asserted asynchronously between edges with busy=1 -> outputs go 0 without waiting for a clock edge. With DELAY_LINE_PARITY_EN, a forced bit flip in stage 2 at delay 4 -> parity_err[0]=1, which holds until reset.
